// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : boot loader turning a length-prefixed big-endian byte stream
// into instruction-memory writes; holds the core in reset until loaded.
// Optional checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;
`endif

    localparam logic [31:0]         MAX_WORDS = 32'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] IDX_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         asm_q, asm_d;
    logic [ADDR_WIDTH:0] idx_q, idx_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                w_xfer;
    logic [15:0]         w_len;
    logic                w_last_word;

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                LEN_HI, LEN_LO, DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM:                 in_ready = 1'b1;
`endif
                default:              in_ready = 1'b0;
            endcase
        end
    end

    assign w_xfer      = in_valid & in_ready;
    assign w_len       = {count_q[15:8], in_data};
    assign w_last_word = (32'(idx_q) + 32'd1) == 32'(count_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            LEN_HI: begin
                if (w_xfer) begin
                    count_d[15:8] = in_data;
                    state_d       = LEN_LO;
                end
            end
            LEN_LO: begin
                if (w_xfer) begin
                    count_d[7:0] = in_data;
                    if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end else if (32'(w_len) > MAX_WORDS) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Word is committed to dedicated output registers so
                        // assembly of the next word can start immediately.
                        wdata_d = {asm_q, in_data};
                        addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                        we_d    = 1'b1;
                        idx_d   = idx_q + IDX_ONE;
                        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = CSUM;
`else
                            state_d = DONE;
`endif
                        end
                    end else begin
                        asm_d = {asm_q[15:0], in_data};
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (w_xfer) begin
                    if (in_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            // Entering DONE from DATA coincides with the last write strobe;
            // done follows one cycle later.
            DONE:    done_d  = 1'b1;
            ERROR:   error_d = 1'b1;
            default: state_d = LEN_HI;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LEN_HI;
            count_q <= 16'd0;
            bcnt_q  <= 2'd0;
            asm_q   <= 24'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'd0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_reset = ~done_q;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle core's instruction fetch unit. It accepts a byte stream (length header, then big-endian instruction words) and writes each assembled word into instruction memory. It holds the core in reset until the image is complete. It lets processor-level and per-instruction benches, and later FPGA bring-up, load programs through one port instead of using `$readmemh`.

## Interface

Parameters:
- ADDR_WIDTH, 8: log2 of instruction memory depth in words; maximum image is 2**ADDR_WIDTH words
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be word-aligned

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte; a byte transfers on a cycle with in_valid & in_ready
- mem_we  output  1  instruction memory write strobe, one cycle per word
- mem_addr  output  32  byte address of write: BASE_ADDR + 4*word_index
- mem_wdata  output  32  assembled instruction word
- cpu_reset  output  1  held high until load completes; drives core/IFU reset
- done  output  1  image loaded successfully; sticky until reset
- error  output  1  image rejected; sticky until reset

## Operation

- Stream format: 2-byte word count N (MSB first), then 4N data bytes (per word MSB first, bits 31:24 arrive first).
- FSM states: LEN_HI, LEN_LO, DATA, CSUM (only with macro), DONE, ERROR. Reset state: LEN_HI.
- LEN_HI: on transfer, latch count[15:8] and go to LEN_LO.
- LEN_LO: on transfer, latch count[7:0]. Then:
  - N == 0 → DONE (or CSUM with macro).
  - N > 2**ADDR_WIDTH → ERROR; no memory writes occur.
  - Otherwise → DATA.
- DATA: a 2-bit byte counter shifts bytes into a 32-bit assembly register. On the 4th byte, the word is registered onto mem_wdata/mem_addr and mem_we pulses the following cycle. word_index then increments. After word N−1 is accepted → DONE (or CSUM).
- DONE / ERROR: terminal; leaving either requires reset.
- in_ready = 1 in LEN_HI, LEN_LO, DATA, CSUM and reset deasserted; 0 otherwise.
- in_valid gaps are allowed anywhere; state and partial word are held.
- mem_addr arithmetic is 32-bit and wraps modulo 2**32. word_index is ADDR_WIDTH+1 bits wide so a full-depth image does not wrap.
- cpu_reset = ~done; ERROR keeps the core in reset.
- Reset mid-load: all registers return to reset values immediately. Already-written memory words are not scrubbed. The next byte is treated as LEN_HI.

## Timing

- Reset values:
  - in_ready 0 (1 in the first cycle after reset deasserts)
  - mem_we 0, mem_addr BASE_ADDR, mem_wdata 0
  - cpu_reset 1, done 0, error 0
- Throughput: one byte per cycle. Back-to-back words produce mem_we every 4 cycles. The write of word k never collides with assembly of word k+1.
- Write latency: mem_we is high exactly one cycle, the cycle after the 4th byte of the word transfers.
- done rises the cycle after the last mem_we. For N == 0 it rises the cycle after the LEN_LO transfer. With the macro, it rises the cycle after the checksum transfer.
- error rises the cycle after the offending transfer.

## Configuration

- IMEM_LOADER_CHECKSUM_EN defined:
  - One extra byte follows the data: XOR of all data bytes (length bytes excluded).
  - CSUM state accepts it. Match → DONE; mismatch → ERROR. Words already written remain in memory.
- Undefined:
  - No CSUM state and no checksum byte expected. The byte after the last data byte is not accepted (in_ready = 0).

## Test plan

- Load N=2, bytes 00 02 20 08 00 05 01 09 50 20 with continuous valid:
  - mem_we pulses twice, 4 cycles apart.
  - Writes are (0x0, 0x20080005) and (0x4, 0x01095020).
  - done=1 and cpu_reset=0 one cycle after the 2nd write.
- Same image with in_valid toggling every other cycle → identical writes and data; done is delayed accordingly; no extra or missing mem_we.
- Header 00 00 → no mem_we; done=1 one cycle after 2nd byte (macro off).
- ADDR_WIDTH=8, header 01 01 (N=257):
  - error=1 and in_ready=0 one cycle after 2nd byte.
  - cpu_reset stays 1; zero writes.
- Assert reset after 6 data bytes of an N=2 load:
  - All outputs return to reset values; word 0 was written, no further writes.
  - A fresh N=1 stream then writes address BASE_ADDR and sets done.
- Macro on, N=1 word 0x12345678:
  - Checksum 0x08 → done.
  - Checksum 0x09 → error=1, cpu_reset stays 1, single write already committed.
